// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT pixel writer path.
package tft_pkg;

  localparam int TFT_ROW_W  = 9;
  localparam int TFT_COL_W  = 10;
  localparam int TFT_PAGE_W = 3;
  localparam int TFT_ADDR_W = TFT_PAGE_W + TFT_ROW_W + TFT_COL_W;

  // Visible panel area; the address counters upstream stay inside it.
  localparam int PANEL_ROWS = 480;
  localparam int PANEL_COLS = 800;

  typedef enum logic [1:0] {COLLECT, REQ, XFER} wr_state_t;

  // SDRAM word address of a pixel: {page, row, col}.
  function automatic logic [TFT_ADDR_W-1:0] pack_addr(
    input logic [TFT_PAGE_W-1:0] page,
    input logic [TFT_ROW_W-1:0]  row,
    input logic [TFT_COL_W-1:0]  col
  );
    return {page, row, col};
  endfunction

endpackage

// File: rtl/tft_burst_buf.sv
// Burst staging buffer: BURST_LEN x 16 register file.
// Writes land at index 'count' and bump it; reads are asynchronous.
module tft_burst_buf
  import tft_pkg::*;
#(
  parameter  int BURST_LEN = 8,
  localparam int IDX_W     = $clog2(BURST_LEN),
  localparam int CNT_W     = IDX_W + 1
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             push,
  input  logic             clr,
  input  logic [15:0]      din,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [15:0]      rd_data,
  output logic [CNT_W-1:0] count
);

  logic [BURST_LEN-1:0][15:0] mem;

  // Append on push; clr empties the buffer once a burst has drained.
  always_ff @(posedge clk) begin
    if (sclr) begin
      mem   <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push && (count < CNT_W'(BURST_LEN))) begin
      mem[count[IDX_W-1:0]] <= din;
      count                 <= count + CNT_W'(1);
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/tft_pixel_writer.sv
// TFT pixel writer: pops pixels from the command controller's one-word FIFO,
// packs address-contiguous runs into bursts and feeds the SDRAM write port.
// Optional macro TFT_WR_STATS_EN enables the saturating burst counter.
module tft_pixel_writer
  import tft_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 1024,
  parameter int ROW_W     = TFT_ROW_W,
  parameter int COL_W     = TFT_COL_W,
  parameter int PAGE_W    = TFT_PAGE_W
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic                          fifo_full,
  input  logic [15:0]                   fifo_data,
  output logic                          fifo_rd_req,
  output logic                          startup_inc,
  input  logic [ROW_W-1:0]              row_add,
  input  logic [COL_W-1:0]              col_add,
  input  logic [PAGE_W-1:0]             page_set,
  output logic                          wr_req,
  input  logic                          wr_ack,
  output logic [PAGE_W+ROW_W+COL_W-1:0] wr_addr,
  output logic [$clog2(BURST_LEN):0]    wr_len,
  input  logic                          wr_data_req,
  output logic [15:0]                   wr_data,
  output logic                          wr_done,
  output logic [15:0]                   burst_cnt
);

  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int CNT_W  = IDX_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam int ADDR_W = PAGE_W + ROW_W + COL_W;

  wr_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDLE_W-1:0] idle_cnt;
  logic              guard;
  logic [PAGE_W-1:0] last_page;
  logic [ROW_W-1:0]  last_row;
  logic [COL_W-1:0]  last_col;
  logic [ADDR_W-1:0] base;
  logic              contig, pop, flush, done;

  // Pop/flush/done decisions. Column contiguity is checked one bit wider so
  // that col 0 following the top column never counts as a continuation.
  always_comb begin
    contig = (page_set == last_page) && (row_add == last_row) &&
             ({1'b0, col_add} == ({1'b0, last_col} + (COL_W+1)'(1)));
    pop    = (state == COLLECT) && fifo_full && !guard &&
             (count < CNT_W'(BURST_LEN)) && ((count == '0) || contig);
    flush  = (state == COLLECT) && (count != '0) && !pop &&
             ((count == CNT_W'(BURST_LEN)) ||
              (fifo_full && !guard && !contig) ||
              (idle_cnt == IDLE_W'(TIMEOUT-1)));
    done   = (state == XFER) && wr_data_req &&
             ({1'b0, rd_ptr} == (count - CNT_W'(1)));
  end

  tft_burst_buf #(.BURST_LEN(BURST_LEN)) u_buf (
    .clk     (clk),
    .sclr    (sclr),
    .push    (pop),
    .clr     (done),
    .din     (fifo_data),
    .rd_idx  (rd_ptr),
    .rd_data (wr_data),
    .count   (count)
  );

  // Collect / request / transfer sequencing with registered handshake outputs.
  // guard mirrors the pop pulse so the next pop waits for upstream to settle.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state       <= COLLECT;
      rd_ptr      <= '0;
      idle_cnt    <= '0;
      guard       <= 1'b0;
      fifo_rd_req <= 1'b0;
      startup_inc <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_len      <= '0;
      wr_done     <= 1'b0;
      last_page   <= '0;
      last_row    <= '0;
      last_col    <= '0;
      base        <= '0;
    end else begin
      fifo_rd_req <= pop;
      startup_inc <= pop;
      guard       <= pop;
      wr_done     <= done;
      case (state)
        COLLECT: begin
          if (pop) begin
            idle_cnt  <= '0;
            last_page <= page_set;
            last_row  <= row_add;
            last_col  <= col_add;
            if (count == '0) base <= pack_addr(page_set, row_add, col_add);
          end else if (flush) begin
            state    <= REQ;
            wr_req   <= 1'b1;
            wr_addr  <= base;
            wr_len   <= count;
            idle_cnt <= '0;
          end else if (count != '0) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        REQ: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            rd_ptr <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (wr_data_req) begin
            if (done) state <= COLLECT;
            else      rd_ptr <= rd_ptr + IDX_W'(1);
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef TFT_WR_STATS_EN
  // Accepted-burst counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (sclr)
      burst_cnt <= '0;
    else if ((state == REQ) && wr_ack && (burst_cnt != 16'hFFFF))
      burst_cnt <= burst_cnt + 16'd1;
  end
`else
  assign burst_cnt = '0;
`endif

endmodule

// File: doc/tft_pixel_writer.md
Name: tft_pixel_writer

Overview:
- Consumer of the one-word pixel FIFO handshake (fifo_full / fifo_data / fifo_rd_req) produced by the TFT command controller.
- Pops pixels, samples the current row/col/page address, and pulses startup_inc to advance the address counters.
- Packs address-contiguous pixels into bursts of up to BURST_LEN words and hands each burst to the SDRAM controller write port.
- Sits between the UART command/TFT control path and the SDRAM arbiter.

Parameters:
- BURST_LEN, 8, maximum words per SDRAM write burst (power of 2, 2..16)
- TIMEOUT, 1024, idle cycles before a partial burst is flushed (>=2)
- ROW_W, 9, row address width
- COL_W, 10, column address width
- PAGE_W, 3, page-select width

Ports:
- clk  in  1  system clock
- sclr  in  1  synchronous active-high reset
- fifo_full  in  1  pixel word valid in command controller
- fifo_data  in  16  RGB565 pixel word
- fifo_rd_req  out  1  single-cycle pop pulse
- startup_inc  out  1  address-advance pulse; identical timing to fifo_rd_req
- row_add  in  ROW_W  current pixel row
- col_add  in  COL_W  current pixel column
- page_set  in  PAGE_W  destination page
- wr_req  out  1  burst write request
- wr_ack  in  1  controller accepts request (1-cycle pulse)
- wr_addr  out  PAGE_W+ROW_W+COL_W  {page,row,col} of first word
- wr_len  out  clog2(BURST_LEN)+1  words in burst, 1..BURST_LEN
- wr_data_req  in  1  controller pops one word this cycle
- wr_data  out  16  buffer word at read pointer, combinational
- wr_done  out  1  1-cycle pulse after last word popped
- burst_cnt  out  16  bursts issued (see Optional Feature)

Behaviour:
- Reset (sclr sampled on clk): state COLLECT; count=0; rd_ptr=0; idle_cnt=0; all outputs 0. Reset mid-burst drops wr_req and discards the buffer. Pixels already popped are lost, which is acceptable.
- States:
  - COLLECT: gather pixels.
  - REQ: hold wr_req.
  - XFER: serve wr_data_req.
- COLLECT pop condition: fifo_full=1, count<BURST_LEN, guard=0, and (count=0 or contiguous).
- Contiguous means page_set==last_page, row_add==last_row, and col_add==last_col+1 (COL_W arithmetic, no wrap credit; col 0 after col max is non-contiguous).
- On pop (registered):
  - fifo_rd_req=startup_inc=1 for exactly 1 cycle.
  - buf[count]<=fifo_data; count++; last_{page,row,col} <= inputs.
  - When count=0, base address <= {page_set,row_add,col_add}.
  - guard set for 1 cycle after each pulse, so a pop is never issued while upstream fifo_full/address are still settling. Maximum rate: 1 pixel per 2 clocks.
- Flush COLLECT->REQ when count>0 and any of:
  - count==BURST_LEN;
  - fifo_full=1, guard=0 and the pixel is not contiguous (that pixel is not popped and stays for the next burst);
  - idle_cnt reaches TIMEOUT-1.
- idle_cnt increments in COLLECT while count>0 and no pop occurs; it clears on pop or on leaving COLLECT.
- REQ: wr_req=1, wr_addr=base, wr_len=count; these are held stable until wr_ack. When wr_ack=1: wr_req<=0, go to XFER, rd_ptr=0.
- XFER: wr_data=buf[rd_ptr]. Each wr_data_req advances rd_ptr. When the word at rd_ptr==count-1 is popped: wr_done pulses the next cycle, count<=0, go to COLLECT.
- wr_data_req outside XFER is ignored. wr_ack outside REQ is ignored.
- No pop occurs in REQ/XFER, so upstream fifo_full backpressures the UART path.

Optional Feature:
- TFT_WR_STATS_EN defined: burst_cnt increments on each wr_ack accepted in REQ and saturates at 16'hFFFF; it clears on sclr.
- Not defined: burst_cnt tied to 0 and the counter logic is omitted.

Decomposition:
- Package tft_pkg holds:
  - widths ROW_W/COL_W/PAGE_W;
  - panel limits 480 rows / 800 columns;
  - the state enum {COLLECT, REQ, XFER};
  - a helper function that packs {page,row,col} into the SDRAM address.
- One sub-module, tft_burst_buf: BURST_LEN x 16 register file with write index, async read index, and count. The FSM stays in the top module.

Test Plan:
- 8 pixels at page 1, row 5, cols 10..17, fifo_full re-asserted 2 cycles after each pop -> single wr_req, wr_addr={3'd1,9'd5,10'd10}, wr_len=8; data returned in push order; wr_done pulses once.
- 3 pixels at cols 20,21,22, then a pixel at row 6 col 0 -> burst wr_len=3 at col 20 with the row-6 pixel not popped; that pixel then starts a new burst at {1,6,0}.
- 2 pixels, then fifo_full held low for TIMEOUT cycles -> wr_req asserts exactly TIMEOUT cycles after the last pop with wr_len=2.
- wr_ack delayed 50 cycles while fifo_full=1 -> wr_req/wr_addr/wr_len stable throughout; zero fifo_rd_req pulses until back in COLLECT.
- sclr asserted during XFER after 3 of 8 words -> next cycle wr_req=0, count=0, state COLLECT; the next pixel starts a fresh burst.
- With TFT_WR_STATS_EN, 5 bursts completed -> burst_cnt=5. Without the macro -> burst_cnt=0.
